// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller: resolves stall requests, decodes
// committed exceptions into flush + redirect PC, and watches for stuck stalls.
module pipe_ctrl_gen #(
    parameter int              STAGES       = 6,
    parameter int              DW           = 32,
    parameter int              FLUSH_CYCLES = 1,
    parameter logic [DW-1:0]   INT_OFF      = 'h20,
    parameter logic [DW-1:0]   EXC_OFF      = 'h40,
    parameter int              TMO_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic [31:0]       excepttype_i,
    input  logic [DW-1:0]     cp0_epc_i,
    input  logic [DW-1:0]     cp0_ebase_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output logic [DW-1:0]     new_pc_o,
    output logic [2:0]        cause_o,
    output logic              stall_tmo_o
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FC_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   r_pc;
    logic [2:0]      r_cause;
    logic [TMO_W-1:0] r_tmo;

    logic              w_exc;
    logic [DW-1:0]     w_dec_pc;
    logic [2:0]        w_dec_cause;
    logic [STAGES-1:0] w_stall_mask;
    logic              w_stalling;

    assign w_exc = (excepttype_i != 32'd0);

    always_comb begin
        w_dec_pc    = cp0_ebase_i + EXC_OFF;
        w_dec_cause = 3'd4;
        case (excepttype_i)
            32'h1: begin
                w_dec_pc    = cp0_ebase_i + INT_OFF;
                w_dec_cause = 3'd1;
            end
            32'h8, 32'hA, 32'hC, 32'hD: begin
                w_dec_cause = 3'd2;
            end
            32'hE: begin
                w_dec_pc    = cp0_epc_i;
                w_dec_cause = 3'd3;
            end
            default: ;
        endcase
    end

    // Stage k stalls if it or any downstream stage requests a stall.
    always_comb begin
        w_stall_mask = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_stall_mask[k] = |(stall_req_i >> k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_exc && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = FC_INIT;
                end
            end
            S_FLUSH: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stall_o  = '0;
        flush_o  = 1'b0;
        new_pc_o = '0;
        cause_o  = 3'd0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_exc) begin
                        flush_o  = 1'b1;
                        new_pc_o = w_dec_pc;
                        cause_o  = w_dec_cause;
                    end else begin
                        stall_o = w_stall_mask;
                    end
                end
                S_FLUSH: begin
                    flush_o  = 1'b1;
                    new_pc_o = r_pc;
                    cause_o  = r_cause;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_cause <= 3'd0;
        end else if (r_state == S_IDLE && w_exc) begin
            r_pc    <= w_dec_pc;
            r_cause <= w_dec_cause;
        end
    end

    assign w_stalling = |stall_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (!w_stalling || flush_o) begin
            r_tmo <= '0;
        end else if (r_tmo != '1) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Fires in the cycle whose edge carries the counter to all-ones.
    assign stall_tmo_o = w_stalling && !flush_o && (r_tmo == TMO_PRE);

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen: three configurations share one stimulus stream
// and are checked against a behavioural model plus literal expectations.
module tb_pipe_ctrl_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  req;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [31:0] ebase;

    logic [5:0]  stall_o [3];
    logic        flush_o [3];
    logic [31:0] pc_o    [3];
    logic [2:0]  cause_o [3];
    logic        tmo_o   [3];

    int checks = 0;
    int errors = 0;

    int fcs  [3] = '{1, 3, 4};
    int tmow [3] = '{4, 4, 8};

    pipe_ctrl_gen #(.FLUSH_CYCLES(1), .TMO_W(4)) u_fc1 (
        .clk(clk), .rst(rst), .stall_req_i(req), .excepttype_i(exc),
        .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall_o(stall_o[0]),
        .flush_o(flush_o[0]), .new_pc_o(pc_o[0]), .cause_o(cause_o[0]),
        .stall_tmo_o(tmo_o[0]));

    pipe_ctrl_gen #(.FLUSH_CYCLES(3), .TMO_W(4)) u_fc3 (
        .clk(clk), .rst(rst), .stall_req_i(req), .excepttype_i(exc),
        .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall_o(stall_o[1]),
        .flush_o(flush_o[1]), .new_pc_o(pc_o[1]), .cause_o(cause_o[1]),
        .stall_tmo_o(tmo_o[1]));

    pipe_ctrl_gen #(.FLUSH_CYCLES(4), .TMO_W(8)) u_fc4 (
        .clk(clk), .rst(rst), .stall_req_i(req), .excepttype_i(exc),
        .cp0_epc_i(epc), .cp0_ebase_i(ebase), .stall_o(stall_o[2]),
        .flush_o(flush_o[2]), .new_pc_o(pc_o[2]), .cause_o(cause_o[2]),
        .stall_tmo_o(tmo_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] e, input logic [31:0] ep,
                                   input logic [31:0] eb,
                                   output logic [31:0] pc,
                                   output logic [2:0] c);
        if (e == 32'h1) begin
            pc = eb + 32'h20;
            c  = 3'd1;
        end else if (e inside {32'h8, 32'hA, 32'hC, 32'hD}) begin
            pc = eb + 32'h40;
            c  = 3'd2;
        end else if (e == 32'hE) begin
            pc = ep;
            c  = 3'd3;
        end else begin
            pc = eb + 32'h40;
            c  = 3'd4;
        end
    endfunction

    // Model: remaining held-flush cycles, held redirect, stall-run length.
    int          rem  [3] = '{0, 0, 0};
    int          run  [3] = '{0, 0, 0};
    logic [31:0] hpc  [3] = '{0, 0, 0};
    logic [2:0]  hc   [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic [5:0]  e_stall;
                logic        e_flush;
                logic [31:0] e_pc;
                logic [2:0]  e_cause;
                logic        e_tmo;
                logic [31:0] dpc;
                logic [2:0]  dc;
                int          top;
                int          tmax;
                e_stall = '0;
                e_flush = 1'b0;
                e_pc    = '0;
                e_cause = '0;
                e_tmo   = 1'b0;
                tmax    = (1 << tmow[i]) - 1;
                if (rst) begin
                    rem[i] = 0;
                    hpc[i] = '0;
                    hc[i]  = '0;
                    run[i] = 0;
                end else begin
                    if (rem[i] > 0) begin
                        e_flush = 1'b1;
                        e_pc    = hpc[i];
                        e_cause = hc[i];
                        rem[i]  = rem[i] - 1;
                    end else if (exc != 0) begin
                        decode(exc, epc, ebase, dpc, dc);
                        e_flush = 1'b1;
                        e_pc    = dpc;
                        e_cause = dc;
                        hpc[i]  = dpc;
                        hc[i]   = dc;
                        rem[i]  = fcs[i] - 1;
                    end else begin
                        top = -1;
                        for (int j = 0; j < 6; j++)
                            if (req[j]) top = j;
                        if (top >= 0) e_stall = 6'((1 << (top + 1)) - 1);
                    end
                    if (e_stall != 0) begin
                        e_tmo  = (run[i] == tmax - 1);
                        run[i] = (run[i] < tmax) ? run[i] + 1 : tmax;
                    end else begin
                        run[i] = 0;
                    end
                end
                chk($sformatf("m%0d.stall", i), 32'(stall_o[i]), 32'(e_stall));
                chk($sformatf("m%0d.flush", i), 32'(flush_o[i]), 32'(e_flush));
                chk($sformatf("m%0d.pc", i), pc_o[i], e_pc);
                chk($sformatf("m%0d.cause", i), 32'(cause_o[i]), 32'(e_cause));
                chk($sformatf("m%0d.tmo", i), 32'(tmo_o[i]), 32'(e_tmo));
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] rq,
                       input logic [31:0] e, input logic [31:0] ep,
                       input logic [31:0] eb);
        @(posedge clk);
        #1;
        rst   = r;
        req   = rq;
        exc   = e;
        epc   = ep;
        ebase = eb;
        #2;
    endtask

    localparam logic [31:0] EB = 32'h8000_0000;

    initial begin
        rst   = 1'b1;
        req   = 6'b000100;
        exc   = '0;
        epc   = '0;
        ebase = '0;
        cyc(1, 6'b000100, 0, 0, 0);
        chk("rst_stall", 32'(stall_o[0]), 32'h0);
        chk("rst_flush", 32'(flush_o[0]), 32'h0);
        cyc(1, 6'b000100, 32'h1, 0, EB);
        chk("rst_pc", pc_o[0], 32'h0);
        chk("rst_cause", 32'(cause_o[0]), 32'h0);

        cyc(0, 6'b000100, 0, 0, EB);
        chk("stall_id", 32'(stall_o[0]), 32'h07);
        chk("stall_id_fl", 32'(flush_o[0]), 32'h0);
        cyc(0, 6'b001100, 0, 0, EB);
        chk("stall_ex", 32'(stall_o[0]), 32'h0F);
        cyc(0, 6'b100000, 0, 0, EB);
        chk("stall_wb", 32'(stall_o[0]), 32'h3F);

        cyc(0, 6'b001000, 32'h1, 0, EB);
        chk("int_flush", 32'(flush_o[0]), 32'h1);
        chk("int_pc", pc_o[0], 32'h8000_0020);
        chk("int_cause", 32'(cause_o[0]), 32'h1);
        chk("int_stall", 32'(stall_o[0]), 32'h0);
        cyc(0, 6'b000000, 0, 0, EB);
        chk("int_done_fl", 32'(flush_o[0]), 32'h0);
        chk("int_done_pc", pc_o[0], 32'h0);
        repeat (4) cyc(0, 0, 0, 0, EB);

        cyc(0, 0, 32'hE, 32'h1234, EB);
        chk("eret1_pc", pc_o[1], 32'h1234);
        chk("eret1_cause", 32'(cause_o[1]), 32'h3);
        cyc(0, 6'b000100, 32'h8, 32'h5678, EB);
        chk("eret2_pc", pc_o[1], 32'h1234);
        chk("eret2_fl", 32'(flush_o[1]), 32'h1);
        cyc(0, 6'b000100, 32'h8, 32'h5678, EB);
        chk("eret3_pc", pc_o[1], 32'h1234);
        chk("eret3_cause", 32'(cause_o[1]), 32'h3);
        cyc(0, 6'b000100, 32'h8, 32'h5678, EB);
        chk("exc4_pc", pc_o[1], 32'h8000_0040);
        chk("exc4_cause", 32'(cause_o[1]), 32'h2);
        repeat (5) cyc(0, 0, 0, 0, EB);

        cyc(0, 0, 32'h7, 0, 32'hFFFF_FFF0);
        chk("wrap_fl", 32'(flush_o[0]), 32'h1);
        chk("wrap_pc", pc_o[0], 32'h0000_0030);
        chk("wrap_cause", 32'(cause_o[0]), 32'h4);
        repeat (5) cyc(0, 0, 0, 0, EB);

        for (int n = 1; n <= 20; n++) begin
            cyc(0, 6'b000010, 0, 0, EB);
            if (n == 14) chk("tmo_pre", 32'(tmo_o[0]), 32'h0);
            if (n == 15) chk("tmo_fire", 32'(tmo_o[0]), 32'h1);
            if (n == 16) chk("tmo_sat", 32'(tmo_o[0]), 32'h0);
        end
        cyc(0, 0, 0, 0, EB);
        for (int n = 1; n <= 16; n++) begin
            cyc(0, 6'b000010, 0, 0, EB);
            if (n == 14) chk("tmo2_pre", 32'(tmo_o[0]), 32'h0);
            if (n == 15) chk("tmo2_fire", 32'(tmo_o[0]), 32'h1);
        end
        repeat (2) cyc(0, 0, 0, 0, EB);

        cyc(0, 0, 32'h1, 0, EB);
        chk("rf_fl1", 32'(flush_o[2]), 32'h1);
        cyc(1, 0, 0, 0, EB);
        chk("rf_rst_fl", 32'(flush_o[2]), 32'h0);
        chk("rf_rst_pc", pc_o[2], 32'h0);
        cyc(0, 0, 0, 0, EB);
        chk("rf_fl", 32'(flush_o[2]), 32'h0);
        chk("rf_stall", 32'(stall_o[2]), 32'h0);
        chk("rf_pc", pc_o[2], 32'h0);
        chk("rf_cause", 32'(cause_o[2]), 32'h0);
        cyc(0, 6'b000100, 0, 0, EB);
        chk("rf_stall_ok", 32'(stall_o[2]), 32'h07);
        repeat (2) cyc(0, 0, 0, 0, EB);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit for the OpenMIPS core, succeeding the fixed 6-stage stall/flush controller. It resolves per-stage stall requests into a stall vector and decodes the committed exception type into a flush plus redirect PC. The redirect PC is formed from a programmable exception base. Flush can be held for a configurable number of cycles via a small sequencer, and a stall-timeout counter flags pipelines stuck in stall. It sits beside the pipeline, fed by the stall sources, the MEM-stage exception logic and CP0, and drives the pipeline registers and the PC register.

Parameters:
STAGES, 6, number of pipeline stages; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB
DW, 32, address/data width
FLUSH_CYCLES, 1, cycles flush_o stays high per exception (>=1)
INT_OFF, 32'h20, interrupt vector offset from ebase
EXC_OFF, 32'h40, general exception vector offset from ebase
TMO_W, 8, stall-timeout counter width; timeout fires at 2^TMO_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_req_i  in  STAGES  stall request; bit k from stage k
excepttype_i  in  32  exception code from MEM stage; 0 = none
cp0_epc_i  in  DW  EPC for eret
cp0_ebase_i  in  DW  exception vector base
stall_o  out  STAGES  stall vector to pipeline registers
flush_o  out  1  flush all pipeline registers
new_pc_o  out  DW  redirect PC, valid while flush_o=1
cause_o  out  3  0 none, 1 int, 2 exc, 3 eret, 4 unknown
stall_tmo_o  out  1  one-cycle pulse on stall timeout

Behaviour:
- Reset: rst sampled on the clk edge; state=IDLE, flush counter=0, held PC=0, held cause=0, timeout counter=0. While rst=1, all outputs are 0, combinational paths included.
- Stall resolution (combinational, IDLE, no exception): let k = highest set bit of stall_req_i. Then stall_o = (1<<(k+1))-1, i.e. stage k and every upstream stage stall. Example: req from ID gives 000111; req from EX gives 001111. If no request, stall_o = 0.
- Exception decode (combinational):
  - code 1 -> ebase+INT_OFF, cause 1
  - codes 8, 0xA, 0xC, 0xD -> ebase+EXC_OFF, cause 2
  - code 0xE -> cp0_epc_i, cause 3
  - any other nonzero code -> ebase+EXC_OFF, cause 4
  - Vector addition is modulo 2^DW.
- Precedence: exception > stall. Whenever flush_o=1, stall_o = 0.
- FSM states: IDLE, FLUSH.
  - IDLE, excepttype_i != 0:
    - Same cycle (zero latency): flush_o=1; new_pc_o and cause_o come from the live decode.
    - Decoded PC and cause are registered.
    - If FLUSH_CYCLES>1, go to FLUSH with counter = FLUSH_CYCLES-1.
  - IDLE, excepttype_i == 0: flush_o=0, new_pc_o=0, cause_o=0.
  - FLUSH: flush_o=1; new_pc_o and cause_o come from the held registers. excepttype_i, stall_req_i, cp0_epc_i and cp0_ebase_i are ignored. Counter decrements each cycle; on reaching 1, return to IDLE next cycle.
  - Net result: flush_o is high for exactly FLUSH_CYCLES consecutive cycles per accepted exception.
  - An exception present in the first IDLE cycle after FLUSH is accepted normally, with back-to-back redirect allowed.
- Stall timeout:
  - Counter increments each cycle stall_o != 0 and saturates at all-ones.
  - It clears to 0 on any cycle with stall_o == 0 or flush_o == 1.
  - stall_tmo_o pulses for one cycle on the transition to all-ones and does not repeat while saturated.
- Reset mid-FLUSH: the next cycle is IDLE with all outputs 0 and no residual flush.

Test Plan:
- Release reset; stall_req_i=000100 (ID) -> stall_o=000111, flush_o=0. Then stall_req_i=001100 -> stall_o=001111.
- ebase=0x8000_0000, FLUSH_CYCLES=1, excepttype=0x1 with stall_req_i=001000 -> same cycle flush_o=1, new_pc_o=0x8000_0020, cause_o=1, stall_o=0. Next cycle with excepttype=0 -> flush_o=0, new_pc_o=0.
- FLUSH_CYCLES=3, excepttype=0xE, epc=0x1234. During flush, change epc to 0x5678 and excepttype to 0x8 -> flush_o high for exactly 3 cycles, new_pc_o=0x1234 throughout, cause_o=3. On cycle 4 with excepttype=0x8 -> new_pc_o=ebase+0x40, cause_o=2.
- excepttype=0x7, ebase=0xFFFF_FFF0 -> flush_o=1, new_pc_o=0x0000_0030 (wrap), cause_o=4.
- TMO_W=4, hold stall_req_i=000010 for 20 cycles -> stall_tmo_o pulses once at cycle 15. Drop the request one cycle, then reassert -> counter restarts and pulses again after 15 cycles.
- FLUSH_CYCLES=4, assert rst during the 2nd flush cycle -> next cycle flush_o=0, stall_o=0, new_pc_o=0, cause_o=0, state IDLE.
